sd_req_arbiter: RTL and testbench

- Shares the single SD sector-transfer port (sd_lba/sd_rd/sd_wr/sd_ack plus sector buffer bus) among NUM requesters, e.g. two 1541 track loaders and a cartridge/tape image loader.
- Each requester keeps its native protocol: it holds rd or wr high until it sees ack, then detects transfer end on the falling edge of ack.
- Arbitration is round-robin per sector transaction, with an optional watchdog on unanswered requests.

---
 rtl/sd_req_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sd_req_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter
//
// Shares one SD sector-transfer port among NUM requesters (for example two
// 1541 track loaders and a cartridge/tape image loader). Each requester keeps
// its native handshake: it holds rd or wr until it sees its ack, then treats
// the falling edge of ack as the end of the sector. Ownership rotates
// round-robin per sector transaction. An optional watchdog aborts requests the
// SD controller never answers.
//
// Parameters
//   NUM      number of requesters (2..4)
//   TIMEOUT  ISSUE cycles allowed before abort; 0 disables the watchdog
//
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   req_lba        per-requester LBA, slice i = [32*i+31:32*i]
//   req_rd/req_wr  per-requester request levels, held until ack
//   req_ack        per-requester ack (sd_ack gated by grant)
//   req_buff_din   per-requester buffer data towards the SD card
//   req_buff_wr    per-requester buffer write strobe
//   req_err        one-cycle pulse to the owner on watchdog abort
//   sd_lba         latched LBA of the granted request
//   sd_rd/sd_wr    command to the SD controller
//   sd_ack         SD controller busy/ack
//   sd_buff_wr     SD buffer write strobe
//   sd_buff_din    buffer data of the owner, 0 outside a transfer
//   grant          one-hot current owner, 0 when idle
//   busy           high in every state except IDLE

module sd_req_arbiter #(
  parameter int NUM     = 2,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [32*NUM-1:0] req_lba,
  input  logic [NUM-1:0]    req_rd,
  input  logic [NUM-1:0]    req_wr,
  output logic [NUM-1:0]    req_ack,
  input  logic [8*NUM-1:0]  req_buff_din,
  output logic [NUM-1:0]    req_buff_wr,
  output logic [NUM-1:0]    req_err,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  input  logic              sd_buff_wr,
  output logic [7:0]        sd_buff_din,
  output logic [NUM-1:0]    grant,
  output logic              busy
);

  localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {DRAIN, IDLE, ISSUE, XFER, RELEASE} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  last, last_nxt;
  logic [IW-1:0]  owner, owner_nxt;
  logic [CW-1:0]  wd_cnt, wd_cnt_nxt;
  logic [NUM-1:0] grant_nxt, req_err_nxt;
  logic [31:0]    sd_lba_nxt;
  logic           sd_rd_nxt, sd_wr_nxt;

  logic [NUM-1:0] pending;
  logic [IW-1:0]  winner;
  logic           found;

  // Round-robin pick: the first pending requester after the last owner,
  // wrapping around, so the previous owner is considered last.
  always_comb begin
    pending = req_rd | req_wr;
    winner  = last;
    found   = 1'b0;
    for (int k = 1; k <= NUM; k++) begin
      if (!found && pending[(int'(last) + k) % NUM]) begin
        winner = IW'((int'(last) + k) % NUM);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= DRAIN;
      grant   <= '0;
      owner   <= '0;
      last    <= IW'(NUM - 1);
      wd_cnt  <= '0;
      sd_lba  <= '0;
      sd_rd   <= 1'b0;
      sd_wr   <= 1'b0;
      req_err <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      owner   <= owner_nxt;
      last    <= last_nxt;
      wd_cnt  <= wd_cnt_nxt;
      sd_lba  <= sd_lba_nxt;
      sd_rd   <= sd_rd_nxt;
      sd_wr   <= sd_wr_nxt;
      req_err <= req_err_nxt;
    end
  end

  // Next-state logic. The command is latched together with the grant, so the
  // requester's inputs no longer matter once ISSUE is entered. DRAIN waits out
  // any transfer the SD controller was running before reset.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    owner_nxt   = owner;
    last_nxt    = last;
    wd_cnt_nxt  = wd_cnt;
    sd_lba_nxt  = sd_lba;
    sd_rd_nxt   = sd_rd;
    sd_wr_nxt   = sd_wr;
    req_err_nxt = '0;
    unique case (state)
      DRAIN: begin
        if (!sd_ack) state_nxt = IDLE;
      end
      IDLE: begin
        if (found && !sd_ack) begin
          state_nxt         = ISSUE;
          owner_nxt         = winner;
          grant_nxt         = '0;
          grant_nxt[winner] = 1'b1;
          sd_lba_nxt        = req_lba[32*int'(winner) +: 32];
          sd_wr_nxt         = req_wr[winner];
          sd_rd_nxt         = !req_wr[winner];
          wd_cnt_nxt        = '0;
        end
      end
      ISSUE: begin
        if (sd_ack) begin
          sd_rd_nxt = 1'b0;
          sd_wr_nxt = 1'b0;
          state_nxt = XFER;
        end else if (TIMEOUT > 0) begin
          // An answer arriving on the abort cycle still wins (checked above).
          if (wd_cnt == CW'(TIMEOUT - 1)) begin
            sd_rd_nxt          = 1'b0;
            sd_wr_nxt          = 1'b0;
            req_err_nxt[owner] = 1'b1;
            grant_nxt          = '0;
            last_nxt           = owner;
            state_nxt          = RELEASE;
          end else begin
            wd_cnt_nxt = wd_cnt + CW'(1);
          end
        end
      end
      XFER: begin
        if (!sd_ack) begin
          grant_nxt = '0;
          last_nxt  = owner;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = DRAIN;
      end
    endcase
  end

  assign busy    = (state != IDLE);
  assign req_ack = {NUM{sd_ack}} & grant;

  // Buffer traffic only flows during XFER; strobes seen elsewhere are dropped.
  always_comb begin
    req_buff_wr = '0;
    sd_buff_din = '0;
    if (state == XFER) begin
      req_buff_wr = {NUM{sd_buff_wr}} & grant;
      sd_buff_din = req_buff_din[8*int'(owner) +: 8];
    end
  end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// tb_sd_req_arbiter
//
// Self-checking bench for sd_req_arbiter (NUM=3, TIMEOUT=16). The bench plays
// the requesters and the SD controller. A transaction-level model predicts the
// round-robin owner from the set of pending requests and the previous owner,
// and the expected LBA, operation, buffer routing and handshake timing follow
// from the requests the bench itself posted.

module tb_sd_req_arbiter;

  localparam int NUM = 3;
  localparam int TO  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [32*NUM-1:0] req_lba;
  logic [NUM-1:0]    req_rd;
  logic [NUM-1:0]    req_wr;
  logic [NUM-1:0]    req_ack;
  logic [8*NUM-1:0]  req_buff_din;
  logic [NUM-1:0]    req_buff_wr;
  logic [NUM-1:0]    req_err;
  logic [31:0]       sd_lba;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din;
  logic [NUM-1:0]    grant;
  logic              busy;

  sd_req_arbiter #(.NUM(NUM), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_lba      (req_lba),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_ack      (req_ack),
    .req_buff_din (req_buff_din),
    .req_buff_wr  (req_buff_wr),
    .req_err      (req_err),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .grant        (grant),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester-side view of the world, owned by the bench.
  logic        m_rd  [NUM];
  logic        m_wr  [NUM];
  logic [31:0] m_lba [NUM];
  logic [7:0]  m_din [NUM];
  int          lastM;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic driveReqs();
    for (int i = 0; i < NUM; i++) begin
      req_rd[i]               = m_rd[i];
      req_wr[i]               = m_wr[i];
      req_lba[32*i +: 32]     = m_lba[i];
      req_buff_din[8*i +: 8]  = m_din[i];
    end
  endtask

  function automatic logic [NUM-1:0] pendMask();
    logic [NUM-1:0] p;
    for (int i = 0; i < NUM; i++) p[i] = m_rd[i] | m_wr[i];
    return p;
  endfunction

  // Owner choice: walk the requesters starting just after the previous owner.
  function automatic int rrPick(input int last, input logic [NUM-1:0] pend);
    int pick;
    pick = -1;
    for (int k = 1; k <= NUM; k++) begin
      if (pick < 0 && pend[(last + k) % NUM]) pick = (last + k) % NUM;
    end
    return pick;
  endfunction

  function automatic logic [NUM-1:0] onehot(input int w);
    logic [NUM-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic newReq(input int i);
    int op;
    op       = $urandom_range(0, 2);
    m_rd[i]  = (op != 1);
    m_wr[i]  = (op != 0);
    m_lba[i] = $urandom;
    m_din[i] = 8'($urandom);
  endtask

  task automatic clearReqs();
    for (int i = 0; i < NUM; i++) begin
      m_rd[i]  = 1'b0;
      m_wr[i]  = 1'b0;
      m_lba[i] = '0;
      m_din[i] = '0;
    end
  endtask

  // Pulse reset for one cycle and check the reset values. Returns on the
  // negedge where reset has just been released with sd_ack low.
  task automatic resetDut();
    @(negedge clk);
    reset      = 1'b1;
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    clearReqs();
    driveReqs();
    @(negedge clk);
    #1;
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_sd_rd", sd_rd, 0);
    checkOutput("rst_sd_wr", sd_wr, 0);
    checkOutput("rst_sd_lba", sd_lba, 0);
    checkOutput("rst_req_err", req_err, 0);
    reset = 1'b0;
    lastM = NUM - 1;
  endtask

  // One complete sector transaction, started on a negedge with the request
  // set already posted. mode 0: random refill and data; 1: the served
  // requester re-requests the same operation; 2: no refill.
  task automatic applyStimulus(input int expLat, input int ackDelay, input int xferLen, input int mode);
    logic [NUM-1:0] oh;
    logic [31:0]    expLba;
    logic           expWr, opRd, opWr;
    int             w, lat, expStrobes, obsStrobes;
    w          = rrPick(lastM, pendMask());
    oh         = onehot(w);
    expWr      = m_wr[w];
    opRd       = m_rd[w];
    opWr       = m_wr[w];
    expLba     = m_lba[w];
    expStrobes = 0;
    obsStrobes = 0;
    lat        = 0;
    do begin
      @(negedge clk);
      sd_buff_wr = 1'b0;
      #1;
      lat++;
      if (lat == 1 && !(sd_rd || sd_wr)) begin
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_grant", grant, 0);
      end
    end while (!(sd_rd || sd_wr) && lat < 12);
    checkOutput("cmd_latency", lat, expLat);
    checkOutput("grant_issue", grant, oh);
    checkOutput("sd_lba", sd_lba, expLba);
    checkOutput("sd_wr_issue", sd_wr, expWr);
    checkOutput("sd_rd_issue", sd_rd, !expWr);
    checkOutput("busy_issue", busy, 1);
    checkOutput("req_ack_issue", req_ack, 0);
    for (int k = 0; k < ackDelay; k++) begin
      @(negedge clk);
      m_lba[w] = $urandom;
      m_rd[w]  = 1'b1;
      m_wr[w]  = !opWr;
      driveReqs();
      #1;
      checkOutput("sd_lba_hold", sd_lba, expLba);
      checkOutput("cmd_hold", {sd_rd, sd_wr}, {!expWr, expWr});
      checkOutput("req_ack_wait", req_ack, 0);
      checkOutput("req_err_wait", req_err, 0);
    end
    @(negedge clk);
    sd_ack = 1'b1;
    m_rd[w] = 1'b0;
    m_wr[w] = 1'b0;
    driveReqs();
    #1;
    checkOutput("req_ack_rise", req_ack, oh);
    checkOutput("cmd_at_ack", {sd_rd, sd_wr}, {!expWr, expWr});
    for (int k = 0; k < xferLen; k++) begin
      @(negedge clk);
      sd_buff_wr = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 0) for (int i = 0; i < NUM; i++) m_din[i] = 8'($urandom);
      driveReqs();
      #1;
      if (sd_buff_wr) expStrobes++;
      if (req_buff_wr[w]) obsStrobes++;
      checkOutput("cmd_clear_xfer", {sd_rd, sd_wr}, 0);
      checkOutput("req_buff_wr", req_buff_wr, sd_buff_wr ? oh : '0);
      checkOutput("sd_buff_din", sd_buff_din, m_din[w]);
      checkOutput("req_ack_xfer", req_ack, oh);
    end
    checkOutput("strobe_count", obsStrobes, expStrobes);
    @(negedge clk);
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    #1;
    checkOutput("req_ack_fall", req_ack, 0);
    checkOutput("grant_fall", grant, oh);
    @(negedge clk);
    sd_buff_wr = 1'b1;
    #1;
    checkOutput("grant_release", grant, 0);
    checkOutput("busy_release", busy, 1);
    checkOutput("buff_wr_release", req_buff_wr, 0);
    checkOutput("buff_din_release", sd_buff_din, 0);
    lastM = w;
    if (mode == 1) begin
      m_rd[w]  = opRd;
      m_wr[w]  = opWr;
      m_lba[w] = expLba + 32'd1;
    end else if (mode == 0) begin
      for (int i = 0; i < NUM; i++) begin
        if (!(m_rd[i] | m_wr[i])) begin
          if ($urandom_range(0, 1) == 1) newReq(i);
        end else if ($urandom_range(0, 7) == 0) begin
          m_rd[i] = 1'b0;
          m_wr[i] = 1'b0;
        end
      end
      if (pendMask() == '0) newReq($urandom_range(0, NUM - 1));
    end
    driveReqs();
  endtask

  // Watchdog: the SD side never answers.
  task automatic watchdogTest();
    int lat, high, errCycles, ackSeen;
    resetDut();
    m_rd[0]  = 1'b1;
    m_lba[0] = 32'h0000_0777;
    driveReqs();
    lat = 0;
    do begin
      @(negedge clk);
      #1;
      lat++;
    end while (!sd_rd && lat < 12);
    checkOutput("wd_cmd_latency", lat, 2);
    high      = 0;
    errCycles = 0;
    ackSeen   = 0;
    while (sd_rd && high < 40) begin
      high++;
      if (req_ack != '0) ackSeen++;
      if (req_err != '0) errCycles++;
      @(negedge clk);
      #1;
    end
    checkOutput("wd_issue_cycles", high, TO);
    checkOutput("wd_req_err", req_err, 3'b001);
    checkOutput("wd_grant", grant, 0);
    if (req_err != '0) errCycles++;
    m_rd[0] = 1'b0;
    driveReqs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (req_err != '0) errCycles++;
      if (req_ack != '0) ackSeen++;
      checkOutput("wd_no_regrant", {sd_rd, sd_wr}, 0);
    end
    checkOutput("wd_err_cycles", errCycles, 1);
    checkOutput("wd_no_ack", ackSeen, 0);
    checkOutput("wd_busy_done", busy, 0);
    lastM = 0;
  endtask

  // Reset while a transfer is in flight and the SD side keeps ack high.
  task automatic resetMidXferTest();
    int lat;
    resetDut();
    m_rd[0]  = 1'b1;
    m_lba[0] = 32'h0000_0055;
    driveReqs();
    lat = 0;
    do begin
      @(negedge clk);
      #1;
      lat++;
    end while (!sd_rd && lat < 12);
    checkOutput("rx_cmd_latency", lat, 2);
    @(negedge clk);
    sd_ack   = 1'b1;
    m_rd[0]  = 1'b0;
    m_rd[1]  = 1'b1;
    m_lba[1] = 32'h0000_0099;
    driveReqs();
    @(negedge clk);
    sd_buff_wr = 1'b1;
    reset      = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rx_grant", grant, 0);
    checkOutput("rx_cmd", {sd_rd, sd_wr}, 0);
    checkOutput("rx_sd_lba", sd_lba, 0);
    checkOutput("rx_req_err", req_err, 0);
    checkOutput("rx_req_ack", req_ack, 0);
    checkOutput("rx_buff_wr", req_buff_wr, 0);
    checkOutput("rx_buff_din", sd_buff_din, 0);
    reset = 1'b0;
    lastM = NUM - 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checkOutput("drain_grant", grant, 0);
      checkOutput("drain_cmd", {sd_rd, sd_wr}, 0);
      checkOutput("drain_req_ack", req_ack, 0);
    end
    @(negedge clk);
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    applyStimulus(2, 1, 2, 2);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset      = 1'b1;
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    clearReqs();
    driveReqs();
    lastM = NUM - 1;
    repeat (2) @(negedge clk);

    // Single read from requester 0, four strobes, ack after a short wait.
    resetDut();
    m_rd[0]  = 1'b1;
    m_lba[0] = 32'h0000_0123;
    driveReqs();
    applyStimulus(2, 2, 4, 2);
    @(negedge clk);
    #1;
    checkOutput("single_idle_busy", busy, 0);
    checkOutput("single_idle_grant", grant, 0);

    // Contention: reader 0 and writer 1 re-requesting after every sector.
    resetDut();
    m_rd[0]  = 1'b1;
    m_lba[0] = 32'h0000_1000;
    m_wr[1]  = 1'b1;
    m_lba[1] = 32'h0000_2000;
    m_din[1] = 8'h5A;
    driveReqs();
    repeat (4) applyStimulus(2, 1, 3, 1);

    // Write path from requester 1 with distinct buffer data per requester.
    resetDut();
    m_wr[1]  = 1'b1;
    m_lba[1] = 32'h0000_0B0B;
    m_din[1] = 8'hA5;
    m_din[0] = 8'h3C;
    driveReqs();
    applyStimulus(2, 0, 3, 2);

    watchdogTest();
    resetMidXferTest();

    // Read and write together: write wins and stays latched.
    resetDut();
    m_rd[0]  = 1'b1;
    m_wr[0]  = 1'b1;
    m_lba[0] = 32'h0000_0600;
    m_din[0] = 8'h66;
    driveReqs();
    applyStimulus(2, 2, 2, 2);

    // Randomized traffic.
    resetDut();
    newReq($urandom_range(0, NUM - 1));
    driveReqs();
    for (int t = 0; t < 40; t++) begin
      applyStimulus(2, $urandom_range(0, 6), $urandom_range(1, 6), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
